divider_control: RTL

//  Sequencing FSM for the unsigned multi-cycle divider: drives the Remainder register's control inputs.

---
 rtl/div_pkg.sv | 40 ++++
 rtl/div_iter_cnt.sv | 30 +++
 rtl/divider_control.sv | 99 +++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types for the multi-cycle divider sequencer: default operand width,
// FSM state encoding and the per-state control-output bundle.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SHIFT0 = 3'd2,
      ITER   = 3'd3,
      FIX    = 3'd4,
      DONE   = 3'd5
   } state_t;

   // Moore outputs of the sequencer (w_ctrl_reg2 is Mealy and lives in the top).
   typedef struct packed {
      logic load;
      logic sll;
      logic srl;
      logic rdy;
      logic busy;
   } ctrl_t;

   // Control outputs that apply while the FSM sits in state s.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c      = '0;
      c.busy = (s != IDLE);
      case (s)
         LOAD:         c.load = 1'b1;
         SHIFT0, ITER: c.sll  = 1'b1;
         FIX:          c.srl  = 1'b1;
         DONE:         c.rdy  = 1'b1;
         default:      ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/div_iter_cnt.sv
// Loadable iteration down-counter for the divider sequencer. Counts down
// while dec is high and parks at zero instead of wrapping; zero flags the
// final iteration.
module div_iter_cnt #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count_reg;

   // Load takes priority; decrement saturates at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/divider_control.sv
// Sequencer for the unsigned shift-subtract-restore divider. Drives the
// Remainder register controls through LOAD, SHIFT0, WIDTH ITER cycles and a
// final FIX right-shift, then pulses rdy for one cycle.
// Optional feature: define DIV_ZERO_CHK_EN to short-circuit a zero divisor
// from LOAD straight to DONE with dz_err set.
module divider_control
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic alu_carry,
   input  logic div_by_zero,
   output logic load_ctrl,
   output logic w_ctrl_reg2,
   output logic SLL_ctrl,
   output logic SRL_ctrl,
   output logic rdy,
   output logic busy,
   output logic dz_err
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t state_reg;
   state_t state_next;
   ctrl_t  ctrl_reg;
   logic   cnt_zero;

   div_iter_cnt #(
      .CNT_W (CNT_W)
   ) u_iter_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (state_reg == LOAD),
      .load_val (CNT_W'(WIDTH - 1)),
      .dec      (state_reg == ITER),
      .zero     (cnt_zero)
   );

   // Next-state selection; ITER leaves once the counter has reached zero.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (run) state_next = LOAD;
`ifdef DIV_ZERO_CHK_EN
         LOAD:    state_next = div_by_zero ? DONE : SHIFT0;
`else
         LOAD:    state_next = SHIFT0;
`endif
         SHIFT0:  state_next = ITER;
         ITER:    if (cnt_zero) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register with outputs registered from the destination state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         ctrl_reg  <= '0;
      end else begin
         state_reg <= state_next;
         ctrl_reg  <= state_ctrl(state_next);
      end
   end

`ifdef DIV_ZERO_CHK_EN
   logic dz_err_reg;

   // Flag only the DONE reached directly from LOAD (zero divisor).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dz_err_reg <= 1'b0;
      end else begin
         dz_err_reg <= (state_reg == LOAD) && (state_next == DONE);
      end
   end

   assign dz_err = dz_err_reg;
`else
   logic unused_div_by_zero;
   assign unused_div_by_zero = div_by_zero;
   assign dz_err             = 1'b0;
`endif

   assign load_ctrl   = ctrl_reg.load;
   assign SLL_ctrl    = ctrl_reg.sll;
   assign SRL_ctrl    = ctrl_reg.srl;
   assign rdy         = ctrl_reg.rdy;
   assign busy        = ctrl_reg.busy;
   // Restore decision: write hi - divisor only when it did not borrow.
   assign w_ctrl_reg2 = (state_reg == ITER) && alu_carry;

endmodule
